btn_conditioner: RTL and testbench

Four-channel push-button front end for the seven-segment animation top level. It feeds the animation-select and speed-control logic, which sits directly downstream. Each raw button input is synchronised and debounced on both press and release, then converted into a registered level plus single-cycle action pulses. Optional hold-to-repeat pulses let speed up/down step continuously while a button is held.

---
 rtl/btn_conditioner.sv | 173 +++++++++++++++++
 tb/tb_btn_conditioner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: four-channel push-button front end.
// Every channel synchronises its raw input, debounces both the press and the
// release, and produces a registered level plus single-cycle action pulses.
// Optional hold-to-repeat pulses are generated while a button stays held.

module btn_channel #(
    parameter int DEBOUNCE_CYCLES = 512,
    parameter int REPEAT_DELAY    = 5_000_000,
    parameter int REPEAT_PERIOD   = 2_000_000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             s;

    // Two-flop synchroniser: the raw button is fully asynchronous.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // Debounce / repeat FSM; level and pulse are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                IDLE: begin
                    level <= 1'b0;
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= ONE;
                    end
                end
                PRESS_WAIT: begin
                    level <= 1'b0;
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                        pulse <= 1'b1;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                HELD: begin
                    level <= 1'b1;
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= ONE;
                    end else if (repeat_en && cnt == RD_LAST) begin
                        // Also covers repeat_en rising after the delay has
                        // already expired: cnt sits saturated at RD_LAST.
                        state <= REPEAT;
                        cnt   <= '0;
                        pulse <= 1'b1;
                    end else if (cnt != RD_LAST) begin
                        cnt <= cnt + ONE;
                    end
                end
                REPEAT: begin
                    level <= 1'b1;
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= ONE;
                    end else if (!repeat_en) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == RP_LAST) begin
                        cnt   <= '0;
                        pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                RELEASE_WAIT: begin
                    level <= 1'b1;
                    if (s) begin
                        // Release bounce: back to held without a new pulse.
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

module btn_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 512,
    parameter int REPEAT_DELAY    = 5_000_000,
    parameter int REPEAT_PERIOD   = 2_000_000,
    parameter int CNT_W           = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic               btn_any
);

    // Channels are fully independent; arbitration happens downstream.
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .raw      (btn_raw[gi]),
            .repeat_en(repeat_en[gi]),
            .level    (btn_level[gi]),
            .pulse    (btn_pulse[gi])
        );
    end

    // Any-button indication built from the registered levels.
    always_comb begin
        btn_any = |btn_level;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with short debounce/repeat parameters.
// Edge e of a scenario is the e-th rising edge that samples its stimulus;
// outputs are sampled on the following falling edge.

module tb_btn_conditioner;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] repeat_en;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_pulse;
    logic          btn_any;

    btn_conditioner #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .repeat_en(repeat_en),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_any  (btn_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] p;
        logic [NB-1:0] l;
        string         nm;
        int            e;
    } exp_t;

    typedef struct {
        logic [NB-1:0] raw;
        logic [NB-1:0] ren;
        logic          rst;
        logic [NB-1:0] p;
        logic [NB-1:0] l;
    } vec_t;

    exp_t          sb[$];
    vec_t          tbl[$];
    int            n_vec = 0;
    int            n_bad = 0;
    bit            pe[64];
    logic [NB-1:0] prev_p = '0;

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic tick(input logic [NB-1:0] raw, input logic [NB-1:0] ren,
                        input logic rst, input logic [NB-1:0] ep,
                        input logic [NB-1:0] el, input string nm, input int e);
        exp_t x;
        x.p = ep; x.l = el; x.nm = nm; x.e = e;
        sb.push_back(x);
        btn_raw   = raw;
        repeat_en = ren;
        reset     = rst;
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        n_vec++;
        if (btn_pulse !== x.p || btn_level !== x.l || btn_any !== (|x.l)) begin
            n_bad++;
            $display("FAIL %s edge %0d: got pulse=%b level=%b any=%b, want pulse=%b level=%b any=%b",
                     x.nm, x.e, btn_pulse, btn_level, btn_any, x.p, x.l, |x.l);
        end
    endtask

    // Pulses must never be high on two consecutive cycles.
    always @(negedge clk) begin
        n_vec++;
        if ((btn_pulse & prev_p) != '0) begin
            n_bad++;
            $display("FAIL back_to_back_pulse: got pulse=%b after %b, want no repeated bit",
                     btn_pulse, prev_p);
        end
        prev_p = btn_pulse;
    end

    task automatic rst_gap(input string nm);
        tick('0, '0, 1'b1, '0, '0, nm, 1);
        tick('0, '0, 1'b1, '0, '0, nm, 2);
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < 64; i++) pe[i] = 1'b0;
    endtask

    // Single held press on the channels in msk; pulse edges come from pe[].
    task automatic press_scn(input string nm, input logic [NB-1:0] msk,
                             input int hi_last, input int ren_from, input int ren_to,
                             input int lv_lo, input int lv_hi, input int n);
        logic [NB-1:0] raw, ren, ep, el;
        for (int e = 1; e <= n; e++) begin
            raw = (e <= hi_last) ? msk : '0;
            ren = (e >= ren_from && e <= ren_to) ? msk : '0;
            ep  = pe[e] ? msk : '0;
            el  = (e >= lv_lo && e <= lv_hi) ? msk : '0;
            tick(raw, ren, 1'b0, ep, el, nm, e);
        end
    endtask

    function automatic void add(input logic [NB-1:0] raw, input logic [NB-1:0] ren,
                                input logic rst, input logic [NB-1:0] p,
                                input logic [NB-1:0] l);
        vec_t v;
        v.raw = raw; v.ren = ren; v.rst = rst; v.p = p; v.l = l;
        tbl.push_back(v);
    endfunction

    initial begin : main
        logic [15:0] bnc;
        logic [NB-1:0] raw, ep, el;

        // Vector table: reset state, then bounce rejection on channel 0
        // (high 3, low 1, high 2, low) with repeat enabled everywhere.
        add('0,    '0, 1'b1, '0, '0);
        add(4'hF, 4'hF, 1'b1, '0, '0);
        add('0,    '0, 1'b1, '0, '0);
        add('0,    '0, 1'b0, '0, '0);
        bnc = 16'b0000_0000_0011_0111;   // bit k = raw[0] at bounce edge k+1
        for (int i = 0; i < 16; i++) add({3'b000, bnc[i]}, 4'hF, 1'b0, '0, '0);

        for (int i = 0; i < tbl.size(); i++)
            tick(tbl[i].raw, tbl[i].ren, tbl[i].rst, tbl[i].p, tbl[i].l, "table", i);

        // Clean press on channel 1, no repeat: one pulse at 6, level 6..35.
        clr_pulses(); pe[6] = 1;
        press_scn("clean_ch1", 4'b0010, 30, 1, 0, 6, 35, 40);
        rst_gap("gap1");

        // Hold-to-repeat on channel 2.
        clr_pulses();
        pe[6] = 1; pe[16] = 1; pe[19] = 1; pe[22] = 1; pe[25] = 1; pe[28] = 1; pe[31] = 1;
        press_scn("repeat_ch2", 4'b0100, 30, 1, 40, 6, 35, 40);
        rst_gap("gap2");

        // repeat_en rises at edge 21 with the delay already saturated:
        // immediate pulse, then every 3 edges, stopping when it drops at 28.
        clr_pulses(); pe[6] = 1; pe[21] = 1; pe[24] = 1; pe[27] = 1;
        press_scn("late_ren_ch1", 4'b0010, 30, 21, 27, 6, 35, 40);
        rst_gap("gap3");

        // Release bounce on channel 0: high 1..10, low 11-12, high 13, low.
        // The four lows sampled by the FSM at edges 16..19 release it.
        for (int e = 1; e <= 24; e++) begin
            raw = (e <= 10 || e == 13) ? 4'b0001 : 4'b0000;
            ep  = (e == 6) ? 4'b0001 : 4'b0000;
            el  = (e >= 6 && e <= 18) ? 4'b0001 : 4'b0000;
            tick(raw, '0, 1'b0, ep, el, "rel_bounce_ch0", e);
        end
        rst_gap("gap4");

        // Simultaneous press on channels 0 and 3.
        clr_pulses(); pe[6] = 1;
        press_scn("simul_1001", 4'b1001, 12, 1, 0, 6, 12, 12);
        rst_gap("gap5");

        // Reset mid-hold on channel 3: reset sampled at edges 10 and 11,
        // edge 12 is the first post-reset sample, so the fresh pulse
        // lands DB+1 edges later at edge 17.
        for (int e = 1; e <= 22; e++) begin
            ep = (e == 6 || e == 17) ? 4'b1000 : 4'b0000;
            el = ((e >= 6 && e <= 9) || e >= 17) ? 4'b1000 : 4'b0000;
            tick(4'b1000, '0, (e == 10 || e == 11), ep, el, "reset_mid_hold", e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation time limit reached, want finish before it");
        $fatal(1);
    end

endmodule
